// File: rtl/alu_pkg.sv
// Shared widths, flag bit positions and the buffered entry type for the ALU
// writeback stage.
package alu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEST_W = 5;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_DEST_W-1:0] dest;
    } entry_t;

    function automatic logic [3:0] pack_flags(
        input logic n,
        input logic z,
        input logic v,
        input logic c
    );
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry skid buffer (main + skid) with a registered ready and a
// synchronous flush; out_data is driven straight from the main entry.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter type item_t = entry_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  in_valid,
    output logic  in_ready,
    input  item_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output item_t out_data
);

    logic  main_valid_r;
    logic  skid_valid_r;
    logic  in_ready_r;
    item_t main_r;
    item_t skid_r;
    logic  in_fire_s;

    assign in_fire_s = in_valid & in_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_r;

    // Entry occupancy and data movement; ready tracks "skid entry empty".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_r       <= '0;
            skid_r       <= '0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            case ({main_valid_r, skid_valid_r})
                2'b00: begin
                    if (in_fire_s) begin
                        main_r       <= in_data;
                        main_valid_r <= 1'b1;
                    end
                end
                2'b10: begin
                    if (out_ready) begin
                        if (in_fire_s) begin
                            main_r <= in_data;
                        end else begin
                            main_valid_r <= 1'b0;
                        end
                    end else if (in_fire_s) begin
                        skid_r       <= in_data;
                        skid_valid_r <= 1'b1;
                        in_ready_r   <= 1'b0;
                    end
                end
                2'b11: begin
                    // Ready is low here, so only the drain path can fire.
                    if (out_ready) begin
                        main_r       <= skid_r;
                        skid_valid_r <= 1'b0;
                        in_ready_r   <= 1'b1;
                    end
                end
                default: begin
                    main_valid_r <= 1'b0;
                    skid_valid_r <= 1'b0;
                    in_ready_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: skid-buffered result path, {N,Z,V,C} flag register
// with carry feedback, and a count of results retired downstream.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEST_W = DEF_DEST_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_carry_i,
    input  logic              alu_overflow_i,
    input  logic [DEST_W-1:0] dest_i,
    input  logic              write_flags_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_result_o,
    output logic [DEST_W-1:0] out_dest_o,
    output logic [3:0]        flags_o,
    output logic              carry_fb_o,
    output logic [15:0]       retire_cnt_o
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DEST_W-1:0] dest;
    } wb_entry_t;

    wb_entry_t   in_entry_s;
    wb_entry_t   out_entry_s;
    logic        in_fire_s;
    logic [3:0]  flags_next_s;
    logic [3:0]  flags_r;
    logic [15:0] retire_cnt_r;

    assign in_entry_s   = '{result: alu_result_i, dest: dest_i};
    assign in_fire_s    = in_valid_i & in_ready_o & ~flush_i;
    assign out_result_o = out_entry_s.result;
    assign out_dest_o   = out_entry_s.dest;
    assign flags_o      = flags_r;
    assign carry_fb_o   = flags_r[FLAG_C];
    assign retire_cnt_o = retire_cnt_r;

    alu_skid_buffer #(
        .item_t(wb_entry_t)
    ) u_skid (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .flush    (flush_i),
        .in_valid (in_valid_i),
        .in_ready (in_ready_o),
        .in_data  (in_entry_s),
        .out_valid(out_valid_o),
        .out_ready(out_ready_i),
        .out_data (out_entry_s)
    );

    // Next flag value: captured from the ALU only on a flag-writing transfer.
    always_comb begin
        flags_next_s = flags_r;
        if (in_fire_s && write_flags_i) begin
            flags_next_s = pack_flags(alu_result_i[DATA_W-1],
                                      (alu_result_i == {DATA_W{1'b0}}),
                                      alu_overflow_i, alu_carry_i);
        end else begin
            flags_next_s = flags_r;
        end
    end

    // Flag register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= flags_next_s;
        end
    end

    // Retire counter; an output beat on a flush edge still counts.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retire_cnt_r <= 16'h0000;
        end else if (out_valid_o && out_ready_i) begin
            retire_cnt_r <= retire_cnt_r + 16'd1;
        end
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DATA_W, default 32, result width; SHALL match the ALU result width.
REQ-002 Parameter DEST_W, default 5, destination-register tag width.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous pipeline flush.
REQ-006 in_valid_i  input  1  ALU result valid.
REQ-007 in_ready_o  output  1  stage can accept a result.
REQ-008 alu_result_i  input  DATA_W  ALU result.
REQ-009 alu_carry_i  input  1  ALU carry_out_flag.
REQ-010 alu_overflow_i  input  1  ALU overflow_flag.
REQ-011 dest_i  input  DEST_W  destination tag travelling with the result.
REQ-012 write_flags_i  input  1  this result updates the flag register.
REQ-013 out_valid_o  output  1  registered result available.
REQ-014 out_ready_i  input  1  consumer accepts the result.
REQ-015 out_result_o  output  DATA_W  registered result.
REQ-016 out_dest_o  output  DEST_W  registered destination tag.
REQ-017 flags_o  output  4  flag register {N,Z,V,C}, bit 3 down to bit 0.
REQ-018 carry_fb_o  output  1  flags_o[0], fed back to ALU carry_in_flag.
REQ-019 retire_cnt_o  output  16  count of results delivered downstream.

Function
REQ-020 Input transfer SHALL occur when in_valid_i & in_ready_o & ~flush_i at a rising edge; output transfer SHALL occur when out_valid_o & out_ready_i.
REQ-021 Buffering SHALL be a 2-entry skid buffer (main, skid); in_ready_o SHALL be registered and equal to "skid entry empty".
REQ-022 Latency SHALL be 1 cycle: a result accepted at edge N into an empty stage appears on out_* with out_valid_o=1 after edge N.
REQ-023 Throughput SHALL be one result per cycle while out_ready_i=1.
REQ-024 When out_ready_i=0 and main is full, an accepted result SHALL go into skid; in_ready_o SHALL drop after that edge.
REQ-025 When main drains and skid is full, skid SHALL move to main on the same edge; in_ready_o SHALL rise after that edge.
REQ-026 Results SHALL leave in acceptance order; no result SHALL be dropped or duplicated except by flush.
REQ-027 out_result_o/out_dest_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-028 Flag register SHALL update on the input-transfer edge when write_flags_i=1: C=alu_carry_i, V=alu_overflow_i, Z=(alu_result_i==0), N=alu_result_i[DATA_W-1]; else it holds.
REQ-029 carry_fb_o SHALL reflect the new C in the cycle after the transfer edge.
REQ-030 retire_cnt_o SHALL increment by 1 per output transfer and wrap from 16'hFFFF to 0.
REQ-031 flush_i=1 SHALL empty both entries (out_valid_o=0, in_ready_o=1 after the edge), suppress any input transfer and flag update that cycle, and leave flags_o and retire_cnt_o unchanged.
REQ-032 An output transfer coincident with flush_i SHALL still count in retire_cnt_o.

Reset
REQ-033 rst_i low SHALL asynchronously clear: out_valid_o=0, both entries empty, in_ready_o=1, out_result_o=0, out_dest_o=0, flags_o=4'b0000, carry_fb_o=0, retire_cnt_o=0.
REQ-034 Reset mid-transfer SHALL discard all buffered results; the first input transfer SHALL occur no earlier than the first rising edge with rst_i high.

Structure
REQ-035 Package alu_pkg SHALL hold DATA_W/DEST_W defaults, flag bit indices (FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3) and the entry typedef {result, dest}.
REQ-036 Sub-module alu_skid_buffer SHALL implement REQ-021..REQ-027 and flush; flag register and retire counter SHALL live in alu_writeback.

Verification
REQ-037 Reset then single result 32'h0000_0000, write_flags_i=1, carry=1 -> out_valid_o next cycle, flags_o=4'b0101, carry_fb_o=1.
REQ-038 Stream 8 results 1..8 with out_ready_i=1 -> 8 consecutive output beats in order, retire_cnt_o=8.
REQ-039 out_ready_i=0, send 32'hA, 32'hB -> in_ready_o=0 after second edge, third input stalls; raise out_ready_i -> A then B delivered, in_ready_o=1.
REQ-040 Result 32'h8000_0000 with write_flags_i=0 after flags=4'b0001 -> flags_o unchanged 4'b0001.
REQ-041 Both entries full, assert flush_i with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, flags_o and retire_cnt_o unchanged.
REQ-042 Preload retire_cnt_o to 16'hFFFF by 65535 transfers, one more transfer -> retire_cnt_o=0; assert rst_i low mid-stall -> all outputs per REQ-033 immediately.
